// File: rtl/module_display_scan.sv
// Time-multiplexed 4-digit common-anode 7-segment driver. The displayed value is
// double-buffered and only swaps on frame boundaries, and each slot opens with anode dead time.
module module_display_scan #(
  parameter int TICKS_PER_DIGIT = 27000,
  parameter int DEAD_TICKS      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] data_i,
  input  logic        blank_lz_i,
  output logic [6:0]  seg_o,
  output logic [3:0]  an_o,
  output logic [1:0]  digit_o,
  output logic        frame_o
);

  localparam int CW = (TICKS_PER_DIGIT > 2) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD_TICKS);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_digit;
  logic [15:0]   r_disp;
  logic [15:0]   r_pend;
  logic          r_pend_flag;

  logic          w_last_tick;
  logic          w_boundary;
  logic          w_dead;
  logic          w_blank;
  logic [3:0]    w_nibble;
  logic [6:0]    w_font;

  always_comb begin
    w_last_tick = (r_cnt == CNT_LAST);
    w_boundary  = w_last_tick && (r_digit == 2'd3);
    w_dead      = (r_cnt < DEAD_CNT);
    w_nibble    = 4'h0;
    w_blank     = 1'b0;
    // A digit is a leading zero only if it and every higher nibble are zero.
    case (r_digit)
      2'd0: begin w_nibble = r_disp[3:0];   w_blank = 1'b0;                    end
      2'd1: begin w_nibble = r_disp[7:4];   w_blank = (r_disp[15:4]  == '0);   end
      2'd2: begin w_nibble = r_disp[11:8];  w_blank = (r_disp[15:8]  == '0);   end
      2'd3: begin w_nibble = r_disp[15:12]; w_blank = (r_disp[15:12] == '0);   end
      default: begin w_nibble = 4'h0;       w_blank = 1'b0;                    end
    endcase
  end

  always_comb begin
    w_font = 7'b1111111;
    case (w_nibble)
      4'h0: w_font = 7'b1000000;
      4'h1: w_font = 7'b1111001;
      4'h2: w_font = 7'b0100100;
      4'h3: w_font = 7'b0110000;
      4'h4: w_font = 7'b0011001;
      4'h5: w_font = 7'b0010010;
      4'h6: w_font = 7'b0000010;
      4'h7: w_font = 7'b1111000;
      4'h8: w_font = 7'b0000000;
      4'h9: w_font = 7'b0010000;
      4'hA: w_font = 7'b0001000;
      4'hB: w_font = 7'b0000011;
      4'hC: w_font = 7'b1000110;
      4'hD: w_font = 7'b0100001;
      4'hE: w_font = 7'b0000110;
      4'hF: w_font = 7'b0001110;
      default: w_font = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_digit     <= 2'd0;
      r_disp      <= 16'h0000;
      r_pend      <= 16'h0000;
      r_pend_flag <= 1'b0;
      seg_o       <= 7'b1111111;
      an_o        <= 4'b1111;
      digit_o     <= 2'd0;
      frame_o     <= 1'b0;
    end else begin
      if (w_last_tick) begin
        r_cnt   <= '0;
        r_digit <= r_digit + 2'd1;
      end else begin
        r_cnt   <= r_cnt + CW'(1);
      end

      // A load landing on the boundary itself bypasses the pending buffer.
      if (w_boundary) begin
        if (load_i)           r_disp <= data_i;
        else if (r_pend_flag) r_disp <= r_pend;
        r_pend_flag <= 1'b0;
      end else if (load_i) begin
        r_pend      <= data_i;
        r_pend_flag <= 1'b1;
      end

      an_o    <= w_dead ? 4'b1111 : ~(4'b0001 << r_digit);
      seg_o   <= (w_dead || (blank_lz_i && w_blank)) ? 7'b1111111 : w_font;
      digit_o <= r_digit;
      frame_o <= w_boundary;
    end
  end

endmodule

// File: tb/tb_module_display_scan.sv
// Scoreboard bench for module_display_scan: a time-indexed reference model pushes the
// expected registered outputs for every clock, and each test pops and compares them.
module tb_module_display_scan;

  localparam int T = 8;
  localparam int D = 2;
  localparam int FR = 4 * T;

  typedef struct packed {
    logic       frame;
    logic [1:0] digit;
    logic [3:0] an;
    logic [6:0] seg;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic        blank;
  logic [6:0]  seg_o;
  logic [3:0]  an_o;
  logic [1:0]  digit_o;
  logic        frame_o;

  always #5 clk = ~clk;

  module_display_scan #(.TICKS_PER_DIGIT(T), .DEAD_TICKS(D)) dut (
    .clk(clk), .rst(rst), .load_i(load), .data_i(data), .blank_lz_i(blank),
    .seg_o(seg_o), .an_o(an_o), .digit_o(digit_o), .frame_o(frame_o)
  );

  logic [6:0] font_t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int          m_t;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_flag;
  obs_t        q[$];
  int          checks = 0;
  int          errors = 0;

  // Model is indexed by cycle-within-frame; it pushes what the outputs must be after this edge.
  task automatic tick();
    obs_t e;
    int cnt, dg;
    bit bnd;
    logic [15:0] sh;
    if (!rst) begin
      e.frame = 1'b0; e.digit = 2'd0; e.an = 4'hF; e.seg = 7'h7F;
      m_t = 0; m_disp = 16'h0; m_pend = 16'h0; m_flag = 0;
    end else begin
      cnt = m_t % T;
      dg  = (m_t / T) % 4;
      bnd = (m_t == FR - 1);
      sh  = m_disp >> (4 * dg);
      e.frame = bnd;
      e.digit = dg[1:0];
      if (cnt < D) begin
        e.an = 4'hF; e.seg = 7'h7F;
      end else begin
        e.an  = ~(4'b0001 << dg);
        e.seg = (blank && dg != 0 && sh == 16'h0) ? 7'h7F : font_t[sh[3:0]];
      end
      if (bnd) begin
        if (load) m_disp = data;
        else if (m_flag) m_disp = m_pend;
        m_flag = 0;
      end else if (load) begin
        m_pend = data;
        m_flag = 1;
      end
      m_t = (m_t + 1) % FR;
    end
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t exp, got;
    rst = 1'b0; load = 1'b0; data = 16'h0; blank = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = q.pop_front();
      got = {frame_o, digit_o, an_o, seg_o};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset cyc %0d got %h expected %h", i, got, exp);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_idle();
    obs_t exp, got;
    int frames = 0;
    blank = 1'b0;
    for (int i = 0; i < FR; i++) begin
      tick();
      exp = q.pop_front();
      got = {frame_o, digit_o, an_o, seg_o};
      if (frame_o === 1'b1) frames++;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL idle cyc %0d got %h expected %h", i, got, exp);
      end
    end
    checks++;
    if (frames !== 1) begin
      errors++;
      $display("FAIL idle_frame_count got %0d expected 1", frames);
    end
  endtask

  task automatic test_load_0123();
    obs_t exp, got;
    bit fired = 0;
    blank = 1'b1;
    for (int i = 0; i < 2 * FR + 8; i++) begin
      load = (!fired && m_t == 5);
      if (load) begin data = 16'h0123; fired = 1; end
      tick();
      load = 1'b0;
      exp = q.pop_front();
      got = {frame_o, digit_o, an_o, seg_o};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL load_0123 cyc %0d got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t exp, got;
    bit f1 = 0, f2 = 0, armed = 0;
    int seen_one = 0;
    blank = 1'b1;
    for (int i = 0; i < 2 * FR + 8; i++) begin
      load = 1'b0;
      if (!f1 && m_t == 10) begin load = 1'b1; data = 16'h1111; f1 = 1; end
      else if (f1 && !f2 && m_t == 12) begin load = 1'b1; data = 16'h2222; f2 = 1; end
      tick();
      load = 1'b0;
      exp = q.pop_front();
      got = {frame_o, digit_o, an_o, seg_o};
      if (armed && an_o !== 4'hF && seg_o === font_t[1]) seen_one++;
      if (f2 && frame_o === 1'b1) armed = 1;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back cyc %0d got %h expected %h", i, got, exp);
      end
    end
    checks++;
    if (seen_one !== 0) begin
      errors++;
      $display("FAIL last_wins_1111_shown got %0d cycles expected 0", seen_one);
    end
  endtask

  task automatic test_zero_blank();
    obs_t exp, got;
    bit fired = 0;
    blank = 1'b1;
    for (int i = 0; i < 2 * FR + 8; i++) begin
      load = (!fired && m_t == 3);
      if (load) begin data = 16'h0000; fired = 1; end
      tick();
      load = 1'b0;
      exp = q.pop_front();
      got = {frame_o, digit_o, an_o, seg_o};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL zero_blank cyc %0d got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_boundary_load();
    obs_t exp, got;
    bit fired = 0;
    int since = -1;
    blank = 1'b0;
    for (int i = 0; i < 2 * FR + 8; i++) begin
      load = (!fired && m_t == FR - 1);
      if (load) begin data = 16'hABCD; fired = 1; since = 0; end
      tick();
      load = 1'b0;
      exp = q.pop_front();
      got = {frame_o, digit_o, an_o, seg_o};
      // Right after the boundary, digit 0 must already show 'd' once dead time ends.
      if (since >= 0) since++;
      if (since == D + 2) begin
        checks++;
        if (seg_o !== 7'b0100001 || an_o !== 4'b1110) begin
          errors++;
          $display("FAIL boundary_first_digit got seg %b an %b expected seg 0100001 an 1110", seg_o, an_o);
        end
      end
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL boundary_load cyc %0d got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t exp, got;
    bit loaded = 0, fired = 0;
    blank = 1'b0;
    for (int i = 0; i < FR + 2 * T + 30; i++) begin
      load = (!loaded && m_t == 3);
      if (load) begin data = 16'h4567; loaded = 1; end
      rst = !(loaded && !fired && m_t == 2 * T + 4);
      if (!rst) fired = 1;
      tick();
      exp = q.pop_front();
      got = {frame_o, digit_o, an_o, seg_o};
      if (!rst) begin
        checks++;
        if (an_o !== 4'hF || seg_o !== 7'h7F || digit_o !== 2'd0) begin
          errors++;
          $display("FAIL reset_mid_outputs got an %b seg %b digit %0d expected 1111 1111111 0", an_o, seg_o, digit_o);
        end
      end
      load = 1'b0;
      rst  = 1'b1;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid cyc %0d got %h expected %h", i, got, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; load = 1'b0; data = 16'h0; blank = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle();
    test_load_0123();
    test_back_to_back();
    test_zero_blank();
    test_boundary_load();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/module_display_scan.md
Name: module_display_scan

Overview:
- Output-side counterpart to the keypad scan path: takes a 4-nibble value (operand A, operand B or sum) and drives a time-multiplexed 4-digit common-anode 7-segment display.
- Double-buffers the value so updates land only on frame boundaries, which prevents tearing.
- Inserts dead time between digits to suppress ghosting.
- Optionally blanks leading zeros.
- Sits after the operand/sum selection logic in module_top, replacing the direct 7-segment path.

Parameters:
- TICKS_PER_DIGIT, 27000: clk cycles per digit slot (1 ms at 27 MHz); legal range ≥ 2.
- DEAD_TICKS, 16: cycles at the start of each slot with all anodes off; legal range 0 ≤ DEAD_TICKS < TICKS_PER_DIGIT.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- load_i  in  1  one-cycle strobe: capture data_i as the next value to display
- data_i  in  16  {millares, centenas, decenas, unidades}, one nibble per digit
- blank_lz_i  in  1  1 = blank leading zero digits
- seg_o  out  7  {g,f,e,d,c,b,a}, active-low
- an_o  out  4  digit anodes, active-low; an_o[0] = unidades
- digit_o  out  2  index of the digit currently being scanned
- frame_o  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (rst=0 at a clk edge):
  - Internal state: tick counter cnt=0, digit=0, disp_reg=0, pend_reg=0, pend_flag=0.
  - Outputs the following cycle: an_o=4'b1111, seg_o=7'b1111111, digit_o=0, frame_o=0.
  - Reset mid-frame aborts immediately and discards pending data.
- Scan sequencing:
  - cnt counts 0..TICKS_PER_DIGIT-1.
  - When cnt reaches its terminal value, cnt returns to 0 and digit advances 0→1→2→3→0.
  - Frame length = 4*TICKS_PER_DIGIT cycles.
- Frame boundary: the cycle with digit=3 and cnt=TICKS_PER_DIGIT-1.
- Output registration:
  - seg_o, an_o, digit_o and frame_o are registered.
  - Value after edge n+1 = f(cnt, digit, disp_reg, blank_lz_i) sampled at edge n, i.e. one-cycle latency.
- Anode drive:
  - All anodes off while cnt < DEAD_TICKS.
  - Otherwise an_o = ~(4'b0001 << digit).
  - During dead time, seg_o=7'b1111111.
- Font, full hex, active-low {g..a}:
  - 0:1000000  1:1111001  2:0100100  3:0110000
  - 4:0011001  5:0010010  6:0000010  7:1111000
  - 8:0000000  9:0010000  A:0001000  b:0000011
  - C:1000110  d:0100001  E:0000110  F:0001110
- Leading-zero blanking, when blank_lz_i=1:
  - Digit k (k = 1..3) is blanked if nibble k and all higher nibbles are 0.
  - A blanked digit has seg_o=1111111; its anode is still driven.
  - Digit 0 is never blanked, so value 0 shows "0".
  - Evaluated against disp_reg, not pend_reg.
- Load / buffer handshake:
  - load_i=1 on a non-boundary cycle: pend_reg<=data_i, pend_flag<=1.
  - A second load before the boundary overwrites pend_reg (last wins).
  - At the boundary with pend_flag=1: disp_reg<=pend_reg, pend_flag<=0.
  - load_i=1 on the boundary cycle itself: disp_reg<=data_i directly, pend_flag<=0; this takes priority over pend_reg.
  - A new value first appears on digit 0 of the next frame.
- frame_o: asserted for exactly one cycle, registered from the boundary cycle, every frame regardless of loads.
- No other inputs are used as handshakes; load_i is accepted on every cycle, so no busy or ready output is needed.

Test Plan (TICKS_PER_DIGIT=8, DEAD_TICKS=2):
- Reset, then 32 cycles idle:
  - an_o is 1111 for cycles 1-2 of each slot, then 1110, 1101, 1011, 0111 in turn.
  - seg_o=1000000 on all digits, blank_lz_i=0.
  - frame_o pulses once per 32 cycles.
- load_i with data_i=16'h0123 at cycle 5, blank_lz_i=1:
  - Digits show 0 until the boundary.
  - In the next frame: digit0=0110000, digit1=0100100, digit2=1111001, digit3 blanked (1111111) with anode active.
- Loads 16'h1111 at cycle 10, then 16'h2222 at cycle 12, same frame: the next frame shows "2222" only; "1111" is never displayed.
- load_i=16'h0000 with blank_lz_i=1: digit0=1000000; digits 1-3 show 1111111.
- load_i=16'hABCD exactly on the boundary cycle: the next frame shows d, C, b, A on digits 0-3 with no extra frame of delay.
- Assert rst for one cycle mid-slot on digit 2 with a pending load:
  - Next cycle: an_o=1111, seg_o=1111111.
  - The scan restarts at digit 0, pending data is discarded, and the display shows 0000.
